// File: rtl/rx_iod_bitalign_pkg.sv
// Shared types and constants for the multi-lane RX IOD bit-alignment trainer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_iod_bitalign_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        CLEAR,
        SETTLE,
        SAMPLE,
        STEP,
        EVAL,
        BACK,
        FAILLOAD,
        NEXT,
        DONE
    } state_e;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Bits needed to hold any tap index 0..tap_max (never less than one bit).
    function automatic int tap_width(input int tap_max);
        return (tap_max < 1) ? 1 : $clog2(tap_max + 1);
    endfunction

endpackage

// File: rtl/bitalign_window_tracker.sv
// Tracks the first contiguous clean eye window seen during one lane's tap sweep.
// Latency: window registers update one cycle after a sample; width/centre/pass are combinational.
// Backpressure: none; the trainer only samples once per tap, cleared on every lane load.
module bitalign_window_tracker
    import rx_iod_bitalign_pkg::*;
#(
    parameter int TAP_W   = 7,
    parameter int WIN_MIN = 4
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             clr_i,
    input  logic             smp_i,
    input  logic             clean_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic             in_win_o,
    output logic [TAP_W-1:0] centre_o,
    output logic             pass_o
);

    logic             in_win_q, in_win_d;
    logic [TAP_W-1:0] start_q, start_d;
    logic [TAP_W-1:0] end_q, end_d;
    logic [TAP_W:0]   width;
    logic [TAP_W:0]   sum;

    // Window next-state: open on the first clean tap, extend while clean.
    always_comb begin
        in_win_d = in_win_q;
        start_d  = start_q;
        end_d    = end_q;
        if (clr_i) begin
            in_win_d = 1'b0;
            start_d  = '0;
            end_d    = '0;
        end else if (smp_i && clean_i) begin
            if (!in_win_q) begin
                start_d  = tap_i;
                in_win_d = 1'b1;
            end
            end_d = tap_i;
        end
    end

    // Window state registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            in_win_q <= 1'b0;
            start_q  <= '0;
            end_q    <= '0;
        end else begin
            in_win_q <= in_win_d;
            start_q  <= start_d;
            end_q    <= end_d;
        end
    end

    // Width and centre use one extra bit so a full-range window cannot wrap.
    always_comb begin
        width    = {1'b0, end_q} - {1'b0, start_q} + (TAP_W+1)'(1);
        sum      = {1'b0, start_q} + {1'b0, end_q};
        centre_o = sum[TAP_W:1];
        in_win_o = in_win_q;
        pass_o   = in_win_q && (width >= (TAP_W+1)'(WIN_MIN));
    end

endmodule

// File: rtl/rx_iod_multilane_bitalign.sv
// Trains each RX IOD lane in turn: sweep taps up, find first clean eye window, park at its centre.
// Latency: per lane roughly (TAP sweep x (SETTLE_CYCLES+3)) + 2 cycles per decrement back to centre.
// Backpressure: none; TRAIN_START is ignored while busy, IOD pulses are fire-and-forget.
module rx_iod_multilane_bitalign
    import rx_iod_bitalign_pkg::*;
#(
    parameter  int NUM_LANES     = 4,
    parameter  int TAP_MAX       = 127,
    parameter  int SETTLE_CYCLES = 8,
    parameter  int WIN_MIN       = 4,
    localparam int TAP_W         = tap_width(TAP_MAX)
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST_N,
    input  logic                       TRAIN_START,
    output logic                       TRAIN_BUSY,
    output logic                       TRAIN_DONE,
    output logic [NUM_LANES-1:0]       LANE_FAIL,
    output logic [NUM_LANES*TAP_W-1:0] LANE_TAP,
    input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
    input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);

    state_e                     state_q, state_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [TAP_W-1:0]           tap_q, tap_d;
    logic [TAP_W-1:0]           centre_q, centre_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       gap_q, gap_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [NUM_LANES-1:0]       fail_q, fail_d;
    logic [NUM_LANES*TAP_W-1:0] lane_tap_q, lane_tap_d;

    logic             clean;
    logic             oor;
    logic             at_max;
    logic             win_open;
    logic             win_pass;
    logic [TAP_W-1:0] win_centre;

    assign clean  = !EYE_MONITOR_EARLY[lane_q] && !EYE_MONITOR_LATE[lane_q];
    assign oor    = DELAY_LINE_OUT_OF_RANGE[lane_q];
    assign at_max = (tap_q == TAP_W'(TAP_MAX));

    bitalign_window_tracker #(
        .TAP_W   (TAP_W),
        .WIN_MIN (WIN_MIN)
    ) u_win (
        .clk_i    (FAB_CLK),
        .arst_n_i (ARST_N),
        .clr_i    (state_q == LOAD),
        .smp_i    (state_q == SAMPLE),
        .clean_i  (clean),
        .tap_i    (tap_q),
        .in_win_o (win_open),
        .centre_o (win_centre),
        .pass_o   (win_pass)
    );

    // IOD control pulses decoded from state; only the active lane's bit can ever be set.
    always_comb begin
        DELAY_LINE_LOAD         = '0;
        EYE_MONITOR_CLEAR_FLAGS = '0;
        DELAY_LINE_MOVE         = '0;
        DELAY_LINE_DIRECTION    = '0;
        case (state_q)
            LOAD, FAILLOAD: DELAY_LINE_LOAD[lane_q] = 1'b1;
            CLEAR:          EYE_MONITOR_CLEAR_FLAGS[lane_q] = 1'b1;
            STEP: begin
                DELAY_LINE_MOVE[lane_q]      = 1'b1;
                DELAY_LINE_DIRECTION[lane_q] = DIR_INC;
            end
            BACK: begin
                if (!gap_q && (tap_q != centre_q)) begin
                    DELAY_LINE_MOVE[lane_q]      = 1'b1;
                    DELAY_LINE_DIRECTION[lane_q] = DIR_DEC;
                end
            end
            default: ;
        endcase
    end

    // Training sequencer next-state logic.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        tap_d      = tap_q;
        centre_d   = centre_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fail_d     = fail_q;
        lane_tap_d = lane_tap_q;
        case (state_q)
            IDLE: begin
                if (TRAIN_START) begin
                    lane_d     = '0;
                    fail_d     = '0;
                    lane_tap_d = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                tap_d   = '0;
                state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                // A clean tap that coincides with saturation is still counted by the tracker.
                if ((!clean && win_open) || oor || at_max) begin
                    state_d = EVAL;
                end else begin
                    state_d = STEP;
                end
            end
            STEP: begin
                tap_d   = tap_q + TAP_W'(1);
                state_d = CLEAR;
            end
            EVAL: begin
                if (win_pass) begin
                    centre_d = win_centre;
                    gap_d    = 1'b0;
                    state_d  = BACK;
                end else begin
                    fail_d[lane_q]                      = 1'b1;
                    lane_tap_d[lane_q*TAP_W +: TAP_W] = '0;
                    state_d                             = FAILLOAD;
                end
            end
            BACK: begin
                // Decrement pulses are spaced by one idle cycle for the delay line.
                if (tap_q == centre_q) begin
                    lane_tap_d[lane_q*TAP_W +: TAP_W] = centre_q;
                    state_d                             = NEXT;
                end else if (!gap_q) begin
                    tap_d = tap_q - TAP_W'(1);
                    gap_d = 1'b1;
                end else begin
                    gap_d = 1'b0;
                end
            end
            FAILLOAD: state_d = NEXT;
            NEXT: begin
                if (lane_q == LANE_W'(NUM_LANES - 1)) begin
                    state_d = DONE;
                end else begin
                    lane_d  = lane_q + LANE_W'(1);
                    state_d = LOAD;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and result registers; reset discards any partial result.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            tap_q      <= '0;
            centre_q   <= '0;
            cnt_q      <= '0;
            gap_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= '0;
            lane_tap_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            tap_q      <= tap_d;
            centre_q   <= centre_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            lane_tap_q <= lane_tap_d;
        end
    end

    assign TRAIN_BUSY = busy_q;
    assign TRAIN_DONE = done_q;
    assign LANE_FAIL  = fail_q;
    assign LANE_TAP   = lane_tap_q;

endmodule
